mem_rd_ctrl: RTL

- Read-side counterpart of the MEM-stage write-enable decoder.
- Decodes memOp = MEM_READ, issues one word read to the data memory, and waits for a variable-latency response.
- Stalls the pipeline while the read is in flight, then returns the load word to the MEM/WB path.
- Detects misaligned addresses and unanswered reads (timeout).

---
 rtl/mem_rd_ctrl_if.sv | 24 ++
 rtl/mem_rd_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/mem_rd_ctrl_if.sv
// Data-memory read port: request/address out from the controller,
// response strobe/data back from the memory.
interface mem_rd_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              memRdReq;
  logic [DATA_W-1:0] memRdAddr;
  logic              memRdValid;
  logic [DATA_W-1:0] memRdData;

  modport master (
    output memRdReq,
    output memRdAddr,
    input  memRdValid,
    input  memRdData
  );

  modport slave (
    input  memRdReq,
    input  memRdAddr,
    output memRdValid,
    output memRdData
  );
endinterface

// File: rtl/mem_rd_ctrl.sv
// MEM-stage load controller: issues one word read per MEM_READ, stalls the
// pipeline until the response (or a timeout) and returns the load word.
module mem_rd_ctrl #(
  parameter int unsigned       TIMEOUT_CYCLES = 16,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [DATA_W-1:0] ERR_DATA       = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          memOp,
  input  logic [DATA_W-1:0]   address,
  mem_rd_ctrl_if.master       mem,
  output logic [DATA_W-1:0]   loadData,
  output logic                loadValid,
  output logic                stallPipe,
  output logic                alignErr,
  output logic                timeoutErr
);

  localparam logic [1:0]  MemRead = 2'b00;
  localparam int unsigned CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            is_read;
  logic            aligned;

  always_comb begin
    is_read   = (memOp == MemRead);
    aligned   = (address[1:0] == 2'b00);
    stallPipe = (state_q == StWait) || ((state_q == StIdle) && is_read && aligned);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mem.memRdReq  <= 1'b0;
      mem.memRdAddr <= '0;
      loadData      <= '0;
      loadValid     <= 1'b0;
      alignErr      <= 1'b0;
      timeoutErr    <= 1'b0;
    end else begin
      mem.memRdReq <= 1'b0;
      loadValid    <= 1'b0;
      alignErr     <= 1'b0;
      timeoutErr   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (is_read) begin
            if (aligned) begin
              mem.memRdAddr <= {address[DATA_W-1:2], 2'b00};
              mem.memRdReq  <= 1'b1;
              cnt_q         <= '0;
              state_q       <= StWait;
            end else begin
              alignErr <= 1'b1;
            end
          end
        end
        StWait: begin
          // A response on the final WAIT cycle takes priority over the timeout.
          if (mem.memRdValid) begin
            loadData  <= mem.memRdData;
            loadValid <= 1'b1;
            state_q   <= StDone;
          end else if (cnt_q == CntLast) begin
            loadData   <= ERR_DATA;
            loadValid  <= 1'b1;
            timeoutErr <= 1'b1;
            state_q    <= StDone;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          // memOp still shows the finished load here; ignore it.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
